// File: rtl/axiuart_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axiuart_frame_pkg
//  Description : Shared framing definitions for the UART host link: start-of-
//                frame markers, CRC-8 polynomial, result codes, parser states
//                and small command-decoding helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package axiuart_frame_pkg;

    // Start-of-frame markers: host-to-device and device-to-host
    localparam logic [7:0] c_sof_host      = 8'hA5;
    localparam logic [7:0] c_sof_device    = 8'h5A;

    // CRC-8 generator x^8 + x^2 + x + 1 (implicit x^8 term)
    localparam logic [7:0] c_crc8_poly     = 8'h07;

    // Result codes reported with every decoded frame
    localparam logic [7:0] c_err_ok        = 8'h00;
    localparam logic [7:0] c_err_crc       = 8'h01;
    localparam logic [7:0] c_err_timeout   = 8'h02;
    localparam logic [7:0] c_err_illegal   = 8'h03;

    // Number of address / data bytes carried in a frame
    localparam int unsigned c_addr_bytes   = 4;
    localparam int unsigned c_data_bytes   = 4;

    // Receive parser states
    typedef enum logic [2:0] {
        PS_IDLE = 3'd0,
        PS_CMD  = 3'd1,
        PS_ADDR = 3'd2,
        PS_DATA = 3'd3,
        PS_CRC  = 3'd4,
        PS_HOLD = 3'd5
    } parser_state_t;

    // Bit 7 clear means the frame carries write data
    function automatic logic cmd_is_read(input logic [7:0] cmd);
        return cmd[7];
    endfunction

    // Bits 6:4 are reserved and must be zero
    function automatic logic cmd_is_illegal(input logic [7:0] cmd);
        return (cmd[6:4] != 3'b000);
    endfunction

endpackage : axiuart_frame_pkg
`default_nettype wire

// File: rtl/crc8_update.sv
`default_nettype none
// ============================================================================
//  Module      : crc8_update
//  Description : Combinational single-byte CRC-8 step (MSB first, poly 0x07).
//                Shared by the frame parser and the frame builder.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc8_update
    import axiuart_frame_pkg::*;
(
    input  logic [7:0] i_crc,
    input  logic [7:0] i_data,
    output logic [7:0] o_crc
);

    logic [7:0] w_crc;

    // Fold the byte into the remainder, then clock eight shift/XOR steps
    always_comb begin
        w_crc = i_crc ^ i_data;
        for (int b = 0; b < 8; b++) begin
            if (w_crc[7]) begin
                w_crc = {w_crc[6:0], 1'b0} ^ c_crc8_poly;
            end else begin
                w_crc = {w_crc[6:0], 1'b0};
            end
        end
    end

    assign o_crc = w_crc;

endmodule : crc8_update
`default_nettype wire

// File: rtl/frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : frame_parser
//  Description : Pops host command frames from a first-word-fall-through RX
//                FIFO, checks SOF / command / CRC-8 / inter-byte timeout and
//                presents one decoded result (with status code) per frame,
//                held until the consumer acknowledges it.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_parser
    import axiuart_frame_pkg::*;
#(
    parameter logic [7:0]  SOF_BYTE       = c_sof_host,
    parameter int unsigned TIMEOUT_CYCLES = 1000
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_fifo_data,
    input  logic        rx_fifo_empty,
    output logic        rx_fifo_read,
    output logic [7:0]  parsed_cmd,
    output logic [31:0] parsed_addr,
    output logic [31:0] parsed_data,
    output logic [7:0]  error_status,
    output logic        frame_valid,
    input  logic        frame_ack
);

    localparam int unsigned     TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_CYCLES - 1);

    parser_state_t      r_state;
    logic [1:0]         r_cnt;
    logic [7:0]         r_crc;
    logic [TMO_W-1:0]   r_tmo;
    logic [7:0]         r_cmd;
    logic [31:0]        r_addr;
    logic [31:0]        r_data;
    logic [7:0]         r_status;
    logic               r_valid;

    logic               w_pop;
    logic               w_in_frame;
    logic               w_timeout;
    logic [7:0]         w_crc_seed;
    logic [7:0]         w_crc_next;

    // Every state except HOLD consumes the head byte whenever one is present
    assign w_pop      = !rx_fifo_empty && (r_state != PS_HOLD);

    // States in which the inter-byte idle timer is running
    assign w_in_frame = (r_state == PS_CMD)  || (r_state == PS_ADDR) ||
                        (r_state == PS_DATA) || (r_state == PS_CRC);

    // Fires on the idle cycle that would bring the timer to TIMEOUT_CYCLES
    assign w_timeout  = w_in_frame && rx_fifo_empty && (r_tmo == c_tmo_last);

    // The command byte starts a fresh CRC; later bytes extend the running one
    assign w_crc_seed = (r_state == PS_CMD) ? 8'h00 : r_crc;

    crc8_update u_crc8 (
        .i_crc  (w_crc_seed),
        .i_data (rx_fifo_data),
        .o_crc  (w_crc_next)
    );

    // Idle timer: counts empty cycles inside a frame, cleared by any pop,
    // frozen outside the frame body
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tmo <= '0;
        end else if (w_in_frame) begin
            if (w_pop) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    // Frame state machine with registered decode results
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= PS_IDLE;
            r_cnt    <= 2'd0;
            r_crc    <= 8'h00;
            r_cmd    <= 8'h00;
            r_addr   <= 32'h0;
            r_data   <= 32'h0;
            r_status <= c_err_ok;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                PS_IDLE: begin
                    // Non-SOF bytes are popped and dropped
                    if (w_pop && (rx_fifo_data == SOF_BYTE)) begin
                        r_data  <= 32'h0;
                        r_state <= PS_CMD;
                    end
                end

                PS_CMD: begin
                    if (w_timeout) begin
                        r_status <= c_err_timeout;
                        r_valid  <= 1'b1;
                        r_state  <= PS_HOLD;
                    end else if (w_pop) begin
                        r_cmd   <= rx_fifo_data;
                        r_crc   <= w_crc_next;
                        r_cnt   <= 2'd0;
                        r_state <= PS_ADDR;
                    end
                end

                PS_ADDR: begin
                    if (w_timeout) begin
                        r_status <= c_err_timeout;
                        r_valid  <= 1'b1;
                        r_state  <= PS_HOLD;
                    end else if (w_pop) begin
                        r_addr[{r_cnt, 3'b000} +: 8] <= rx_fifo_data;
                        r_crc <= w_crc_next;
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state <= cmd_is_read(r_cmd) ? PS_CRC : PS_DATA;
                        end
                    end
                end

                PS_DATA: begin
                    if (w_timeout) begin
                        r_status <= c_err_timeout;
                        r_valid  <= 1'b1;
                        r_state  <= PS_HOLD;
                    end else if (w_pop) begin
                        r_data[{r_cnt, 3'b000} +: 8] <= rx_fifo_data;
                        r_crc <= w_crc_next;
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state <= PS_CRC;
                        end
                    end
                end

                PS_CRC: begin
                    if (w_timeout) begin
                        r_status <= c_err_timeout;
                        r_valid  <= 1'b1;
                        r_state  <= PS_HOLD;
                    end else if (w_pop) begin
                        // An illegal command outranks a CRC mismatch
                        if (cmd_is_illegal(r_cmd)) begin
                            r_status <= c_err_illegal;
                        end else if (rx_fifo_data != r_crc) begin
                            r_status <= c_err_crc;
                        end else begin
                            r_status <= c_err_ok;
                        end
                        r_valid <= 1'b1;
                        r_state <= PS_HOLD;
                    end
                end

                PS_HOLD: begin
                    if (frame_ack) begin
                        r_valid <= 1'b0;
                        r_state <= PS_IDLE;
                    end
                end

                default: begin
                    r_valid <= 1'b0;
                    r_state <= PS_IDLE;
                end
            endcase
        end
    end

    assign rx_fifo_read = w_pop;
    assign parsed_cmd   = r_cmd;
    assign parsed_addr  = r_addr;
    assign parsed_data  = r_data;
    assign error_status = r_status;
    assign frame_valid  = r_valid;

endmodule : frame_parser
`default_nettype wire

// File: tb/tb_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_parser
//  Description : Self-checking bench for frame_parser. A queue models the
//                RX FIFO; expected results come from a frame-level model
//                (CRC by polynomial long division over the whole message).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_frame_parser;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_fifo_data;
    logic        rx_fifo_empty;
    logic        rx_fifo_read;
    logic [7:0]  parsed_cmd;
    logic [31:0] parsed_addr;
    logic [31:0] parsed_data;
    logic [7:0]  error_status;
    logic        frame_valid;
    logic        frame_ack;

    int          vectors     = 0;
    int          miscompares = 0;
    bq_t         q;
    bit          pend = 1'b0;
    int          pops = 0;
    logic [31:0] m_addr = 32'h0;

    always #5 clk = ~clk;

    frame_parser #(
        .SOF_BYTE       (8'hA5),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_fifo_data  (rx_fifo_data),
        .rx_fifo_empty (rx_fifo_empty),
        .rx_fifo_read  (rx_fifo_read),
        .parsed_cmd    (parsed_cmd),
        .parsed_addr   (parsed_addr),
        .parsed_data   (parsed_data),
        .error_status  (error_status),
        .frame_valid   (frame_valid),
        .frame_ack     (frame_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // CRC as the remainder of (message * x^8) mod (x^8 + x^2 + x + 1)
    function automatic logic [7:0] model_crc(input bq_t msg);
        logic [8:0] rem;
        bit         bits[$];
        rem = 9'h0;
        foreach (msg[i]) for (int b = 7; b >= 0; b--) bits.push_back(msg[i][b]);
        repeat (8) bits.push_back(1'b0);
        foreach (bits[i]) begin
            rem = {rem[7:0], bits[i]};
            if (rem[8]) rem = rem ^ 9'h107;
        end
        return rem[7:0];
    endfunction

    task automatic make_frame(input logic [7:0] cmd, input logic [31:0] addr,
                              input logic [31:0] data, input logic [7:0] flip,
                              output bq_t f);
        bq_t body;
        body = {};
        body.push_back(cmd);
        for (int i = 0; i < 4; i++) body.push_back(addr[8*i +: 8]);
        if (!cmd[7]) for (int i = 0; i < 4; i++) body.push_back(data[8*i +: 8]);
        f = body;
        f.push_front(8'hA5);
        f.push_back(model_crc(body) ^ flip);
    endtask

    function automatic logic [7:0] model_status(input logic [7:0] cmd, input logic [7:0] flip);
        if (cmd[6:4] != 3'b000) return 8'h03;
        if (flip != 8'h00)      return 8'h01;
        return 8'h00;
    endfunction

    // One clock: retire the pop of the previous edge, present the FIFO head,
    // then note whether the DUT will pop at the coming edge
    task automatic tick();
        @(negedge clk);
        if (pend) begin
            void'(q.pop_front());
            pops++;
        end
        rx_fifo_empty = (q.size() == 0);
        rx_fifo_data  = rx_fifo_empty ? 8'h00 : q[0];
        #1;
        pend = rx_fifo_read;
    endtask

    task automatic push(input bq_t f);
        foreach (f[i]) q.push_back(f[i]);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (frame_valid !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk({tag, " valid"}, {31'h0, frame_valid}, 32'h1);
    endtask

    task automatic expect_result(input string tag, input logic [7:0] cmd, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [7:0] st);
        wait_valid(tag);
        chk({tag, " cmd"},    {24'h0, parsed_cmd},   {24'h0, cmd});
        chk({tag, " addr"},   parsed_addr,           addr);
        chk({tag, " data"},   parsed_data,           data);
        chk({tag, " status"}, {24'h0, error_status}, {24'h0, st});
        m_addr    = addr;
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk({tag, " valid drop"}, {31'h0, frame_valid}, 32'h0);
    endtask

    initial begin
        bq_t         f;
        bq_t         g;
        int          n;
        int          k;
        logic [7:0]  cmd;
        logic [7:0]  flip;
        logic [31:0] addr;
        logic [31:0] data;

        reset         = 1'b0;
        frame_ack     = 1'b0;
        rx_fifo_empty = 1'b1;
        rx_fifo_data  = 8'h00;
        q             = {};

        // Reset state
        repeat (3) tick();
        chk("reset cmd",    {24'h0, parsed_cmd},   32'h0);
        chk("reset addr",   parsed_addr,           32'h0);
        chk("reset data",   parsed_data,           32'h0);
        chk("reset status", {24'h0, error_status}, 32'h0);
        chk("reset valid",  {31'h0, frame_valid},  32'h0);
        reset = 1'b1;
        tick();

        // Back-to-back read frame: one pop per cycle, result right after CRC pop
        q = {8'hA5, 8'h80, 8'h00, 8'h10, 8'h00, 8'h00, 8'h35};
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("pop cycle %0d", i), {31'h0, pend}, 32'h1);
            chk($sformatf("no early valid %0d", i), {31'h0, frame_valid}, 32'h0);
        end
        tick();
        chk("valid after crc pop", {31'h0, frame_valid}, 32'h1);
        expect_result("read frame", 8'h80, 32'h0000_1000, 32'h0, 8'h00);

        // Write frame, good CRC then corrupted CRC
        make_frame(8'h01, 32'h1234_5678, 32'hDEAD_BEEF, 8'h00, f);
        push(f);
        expect_result("write ok", 8'h01, 32'h1234_5678, 32'hDEAD_BEEF, 8'h00);
        make_frame(8'h01, 32'h1234_5678, 32'hDEAD_BEEF, 8'h01, f);
        push(f);
        expect_result("write badcrc", 8'h01, 32'h1234_5678, 32'hDEAD_BEEF, 8'h01);

        // Garbage ahead of a frame
        q = {8'h00, 8'hFF, 8'h5A};
        make_frame(8'h80, 32'hCAFE_0042, 32'h0, 8'h00, f);
        push(f);
        expect_result("garbage", 8'h80, 32'hCAFE_0042, 32'h0, 8'h00);

        // Illegal command
        make_frame(8'h90, 32'h0000_0ABC, 32'h0, 8'h00, f);
        push(f);
        expect_result("illegal", 8'h90, 32'h0000_0ABC, 32'h0, 8'h03);

        // Stall after two address bytes until timeout
        q = {8'hA5, 8'h01, 8'h78, 8'h56};
        k = 0;
        while (pops < 0 + pops && k < 0) k++;
        k = 0;
        n = pops + 4;
        while (pops < n && k < 50) begin tick(); k++; end
        k = 0;
        while (frame_valid !== 1'b1 && k < 1100) begin tick(); k++; end
        chk("timeout latency", k, 32'd1000);
        expect_result("timeout", 8'h01, {m_addr[31:16], 16'h5678}, 32'h0, 8'h02);

        // 999 idle cycles is still within budget
        make_frame(8'h02, 32'h8765_4321, 32'h0BAD_F00D, 8'h00, f);
        for (int i = 0; i < 4; i++) q.push_back(f[i]);
        k = 0;
        n = pops + 4;
        while (pops < n && k < 50) begin tick(); k++; end
        repeat (998) tick();
        chk("no timeout at 999", {31'h0, frame_valid}, 32'h0);
        for (int i = 4; i < f.size(); i++) q.push_back(f[i]);
        expect_result("stall 999", 8'h02, 32'h8765_4321, 32'h0BAD_F00D, 8'h00);

        // Result held while unacknowledged, next frame already queued
        make_frame(8'h83, 32'h0000_00F0, 32'h0, 8'h00, f);
        make_frame(8'h04, 32'h1111_2222, 32'h3333_4444, 8'h00, g);
        push(f);
        push(g);
        wait_valid("hold");
        n = pops;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("hold no pop %0d", i), {31'h0, pend}, 32'h0);
            chk($sformatf("hold addr %0d", i), parsed_addr, 32'h0000_00F0);
        end
        chk("hold pop count", pops, n);
        expect_result("hold first", 8'h83, 32'h0000_00F0, 32'h0, 8'h00);
        expect_result("hold second", 8'h04, 32'h1111_2222, 32'h3333_4444, 8'h00);

        // Reset in the middle of the address field
        make_frame(8'h05, 32'h7777_6666, 32'h5555_4444, 8'h00, f);
        push(f);
        k = 0;
        n = pops + 4;
        while (pops < n && k < 50) begin tick(); k++; end
        reset = 1'b0;
        tick();
        q.delete();
        pend = 1'b0;
        chk("midreset cmd",    {24'h0, parsed_cmd},   32'h0);
        chk("midreset addr",   parsed_addr,           32'h0);
        chk("midreset data",   parsed_data,           32'h0);
        chk("midreset status", {24'h0, error_status}, 32'h0);
        chk("midreset valid",  {31'h0, frame_valid},  32'h0);
        reset  = 1'b1;
        m_addr = 32'h0;
        tick();
        make_frame(8'h06, 32'hA0B0_C0D0, 32'h0102_0304, 8'h00, f);
        push(f);
        expect_result("after reset", 8'h06, 32'hA0B0_C0D0, 32'h0102_0304, 8'h00);

        // Randomized frames with garbage, gaps, illegal commands, bad CRCs
        for (int t = 0; t < 25; t++) begin
            cmd  = 8'($urandom);
            if ($urandom_range(0, 3) != 0) cmd[6:4] = 3'b000;
            addr = $urandom;
            data = $urandom;
            flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            make_frame(cmd, addr, data, flip, f);
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
                logic [7:0] gb;
                gb = 8'($urandom);
                if (gb == 8'hA5) gb = 8'h00;
                f.push_front(gb);
            end
            foreach (f[i]) begin
                q.push_back(f[i]);
                repeat ($urandom_range(0, 2)) tick();
            end
            expect_result($sformatf("rand %0d", t), cmd, addr,
                          cmd[7] ? 32'h0 : data, model_status(cmd, flip));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_frame_parser
`default_nettype wire
